// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide execute unit.
// Holds the operation codes and the control state enumeration.
package muldiv_pkg;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_MULHU = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_REMU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The upper opcode bit separates the divide family from the multiply family.
   function automatic logic is_div(input logic [1:0] code);
      return code[1];
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply and restoring divide.
// One operation in flight, one result bit step per cycle, result written back to the regfile.
module muldiv_unit #(
   parameter int WORD = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [WORD-1:0] opa,
   input  logic [WORD-1:0] opb,
   input  logic [4:0]      rd,
   output logic            busy,
   output logic            done,
   output logic [WORD-1:0] result,
   output logic [4:0]      waddr,
   output logic            we
);

   import muldiv_pkg::*;

   localparam int CW = $clog2(WORD) + 1;
   localparam logic [CW-1:0] LAST = CW'(WORD - 1);

   state_t            state;
   state_t            state_next;
   logic [1:0]        op_q;
   logic [WORD-1:0]   opa_q;
   logic [WORD-1:0]   opb_q;
   logic [CW-1:0]     count;
   logic [2*WORD:0]   acc;
   logic [2*WORD:0]   acc_next;
   logic [WORD:0]     mul_sum;
   logic [WORD:0]     rem_shift;
   logic [WORD:0]     rem_trial;
   logic [WORD-1:0]   final_result;
   logic              div_zero;

   assign div_zero = is_div(op) && (opb == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      we         = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next = div_zero ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (count == LAST) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            we         = (waddr != 5'd0);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // acc is shared: {product} for multiply, {partial remainder, quotient} for divide.
   always_comb begin
      acc_next  = acc;
      mul_sum   = '0;
      rem_shift = '0;
      rem_trial = '0;
      if (is_div(op_q)) begin
         rem_shift = {acc[2*WORD-1:WORD], acc[WORD-1]};
         rem_trial = rem_shift - {1'b0, opb_q};
         if (!rem_trial[WORD]) begin
            acc_next = {rem_trial, acc[WORD-2:0], 1'b1};
         end else begin
            acc_next = {rem_shift, acc[WORD-2:0], 1'b0};
         end
      end else begin
         mul_sum  = {1'b0, acc[2*WORD-1:WORD]} + (acc[0] ? {1'b0, opa_q} : {(WORD+1){1'b0}});
         acc_next = {1'b0, mul_sum, acc[WORD-1:1]};
      end
   end

   // Low half holds the product low word or quotient; high half the product high word or remainder.
   assign final_result = op_q[0] ? acc_next[2*WORD-1:WORD] : acc_next[WORD-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= OP_MUL;
         opa_q  <= '0;
         opb_q  <= '0;
         count  <= '0;
         acc    <= '0;
         result <= '0;
         waddr  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= op;
                  opa_q <= opa;
                  opb_q <= opb;
                  waddr <= rd;
                  count <= '0;
                  acc   <= {{(WORD+1){1'b0}}, (is_div(op) ? opa : opb)};
                  if (div_zero) begin
                     result <= (op == OP_DIVU) ? {WORD{1'b1}} : opa;
                  end
               end
            end
            RUN: begin
               acc   <= acc_next;
               count <= count + CW'(1);
               if (count == LAST) begin
                  result <= final_result;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences and random ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

   localparam int WORD = 32;

   logic            clk;
   logic            rst;
   logic            start;
   logic [1:0]      op;
   logic [WORD-1:0] opa;
   logic [WORD-1:0] opb;
   logic [4:0]      rd;
   logic            busy;
   logic            done;
   logic [WORD-1:0] result;
   logic [4:0]      waddr;
   logic            we;

   int vectors;
   int miscompares;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[9];

   muldiv_unit #(.WORD(WORD)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .opa    (opa),
      .opb    (opb),
      .rd     (rd),
      .busy   (busy),
      .done   (done),
      .result (result),
      .waddr  (waddr),
      .we     (we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      case (o)
         2'd0:    return p[31:0];
         2'd1:    return p[63:32];
         2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives a start request; returns at the falling edge after the accepting edge.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      opa   = a;
      opb   = b;
      rd    = r;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      opa   = $urandom;
      opb   = $urandom;
      rd    = 5'($urandom);
   endtask

   task automatic waitDone(output int edges);
      edges = 0;
      while (done !== 1'b1 && edges < 200) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [31:0] exp);
      int edges;
      int expLat;
      expLat = (o[1] && b == 0) ? 0 : WORD;
      applyStimulus(o, a, b, r);
      waitDone(edges);
      checkOutput({tag, " latency"}, 64'(edges), 64'(expLat));
      checkOutput({tag, " result"}, 64'(result), 64'(exp));
      checkOutput({tag, " waddr"}, 64'(waddr), 64'(r));
      checkOutput({tag, " we/busy"}, {62'd0, we, busy}, {62'd0, (r != 0), 1'b1});
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, " after done busy/done/we"}, {61'd0, busy, done, we}, 64'd0);
      checkOutput({tag, " result held"}, 64'(result), 64'(exp));
   endtask

   initial begin
      int   edges;
      logic sawPulse;
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      vectors     = 0;
      miscompares = 0;
      rst   = 1'b1;
      start = 1'b0;
      op    = 2'd0;
      opa   = '0;
      opb   = '0;
      rd    = '0;

      vecs[0] = '{2'd0, 32'd7,          32'd6,          5'd3,  32'd42};
      vecs[1] = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'hFFFF_FFFE};
      vecs[2] = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0001};
      vecs[3] = '{2'd2, 32'd100,        32'd7,          5'd8,  32'd14};
      vecs[4] = '{2'd3, 32'd100,        32'd7,          5'd9,  32'd2};
      vecs[5] = '{2'd2, 32'd123,        32'd0,          5'd10, 32'hFFFF_FFFF};
      vecs[6] = '{2'd3, 32'd123,        32'd0,          5'd11, 32'd123};
      vecs[7] = '{2'd0, 32'd3,          32'd4,          5'd0,  32'd12};
      vecs[8] = '{2'd2, 32'd7,          32'd0,          5'd0,  32'hFFFF_FFFF};

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset state", {busy, done, we, waddr, result}, '0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);
      end

      // A start pulse during RUN must neither restart nor alter the operation in flight.
      applyStimulus(2'd0, 32'd9, 32'd9, 5'd5);
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      start = 1'b1;
      op    = 2'd0;
      opa   = 32'd5;
      opb   = 32'd5;
      rd    = 5'd7;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      waitDone(edges);
      checkOutput("busy start latency", 64'(edges + 5), 64'(WORD));
      checkOutput("busy start result", 64'(result), 64'd81);
      checkOutput("busy start waddr", 64'(waddr), 64'd5);
      sawPulse = 1'b0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         sawPulse = sawPulse | done | we | busy;
      end
      checkOutput("busy start not queued", 64'(sawPulse), 64'd0);

      // Reset in the tenth RUN cycle discards the operation.
      applyStimulus(2'd0, 32'd1234, 32'd5678, 5'd9);
      repeat (9) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("mid-run reset", {busy, done, we, waddr, result}, '0);
      rst = 1'b0;
      sawPulse = 1'b0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         sawPulse = sawPulse | done | we | busy;
      end
      checkOutput("no done after reset", 64'(sawPulse), 64'd0);
      runOp("post-reset divu", 2'd2, 32'd50, 32'd5, 5'd4, 32'd10);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
         case ($urandom_range(0, 4))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         runOp($sformatf("rand%0d", i), ro, ra, rb, 5'($urandom_range(0, 31)), refModel(ro, ra, rb));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide execute unit for the CPU datapath. It sits directly downstream of the register file. It takes the two read-port values as operands and the destination register index as a tag. After a fixed multi-cycle computation it returns the result to the register file write port (data, waddr, we). One operation is in flight at a time, and the unit reports busy status to the control logic.

## Interface
- WORD, 32: operand/result width (≥ 2).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; accepted only in IDLE.
- op  in  2  00 MUL (low WORD bits), 01 MULHU (high WORD bits), 10 DIVU (quotient), 11 REMU (remainder).
- opa  in  WORD  operand A / dividend (regfile qa).
- opb  in  WORD  operand B / divisor (regfile qb).
- rd  in  5  destination register index.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse, result valid.
- result  out  WORD  result; held stable from DONE until the next accepted start.
- waddr  out  5  latched rd; drives regfile waddr.
- we  out  1  regfile write enable; equals done when latched rd ≠ 0, else 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1: latch op, opa, opb, rd.
  - Divide op with opb=0: go to DONE.
  - Otherwise: clear the accumulator, set count=0, go to RUN.
- IDLE with start=0: stay.
- RUN: one iteration per cycle, count increments. After the WORD-th iteration, go to DONE.
- DONE: done=1 and we per the rd rule; result updated. Next edge goes to IDLE unconditionally.
- start while busy: ignored, with no effect on latched operands.
- MUL/MULHU: shift-add over a 2·WORD product register. Unsigned.
- DIVU/REMU: restoring division with a WORD+1-bit partial remainder. Unsigned.
- Divide by zero: quotient = all ones; remainder = opa. No fault signal.
- All arithmetic wraps modulo 2^WORD in the output; no overflow flag.
- rd = 0: result is computed and done pulses, but we stays 0.
- Reset, at any time including mid-RUN: IDLE, busy=0, done=0, we=0, result=0, waddr=0, count=0. Any in-flight operation is discarded with no done or we.

## Timing
- Start accepted at edge E. Normal ops: RUN during edges E+1..E+WORD; done/we high for the cycle after edge E+WORD. Latency is WORD+1 cycles from the accepting edge.
- Divide by zero: done high for the cycle after edge E. Latency is 1.
- busy rises the cycle after E and falls the cycle after done.
- Earliest next start accepted: the edge after DONE. Back-to-back throughput is WORD+2 cycles.
- Outputs are registered. No combinational path from inputs to outputs.
- The regfile samples data/waddr/we on the same clk edge that ends the DONE cycle.

## Structure
- Package muldiv_pkg: op encodings (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU) and the state enum (IDLE, RUN, DONE).
- Single module. The iteration datapath (product/remainder shift register, counter) is small enough that no sub-module is warranted.
- Counter width: $clog2(WORD)+1.

## Test plan
- MUL opa=7, opb=6, rd=3 → done exactly 33 cycles after the accepting edge; result=42, waddr=3, we=1 for one cycle.
- MULHU opa=opb=0xFFFFFFFF → result=0xFFFFFFFE. Then MUL with the same operands → result=0x00000001.
- DIVU 100/7 → result=14. REMU 100/7 → result=2. Both with 33-cycle latency.
- DIVU 123/0 → result=0xFFFFFFFF with done one cycle after accept. REMU 123/0 → result=123.
- Boundary cases:
  - Pulse start with op=MUL, 5×5 during RUN of a 9×9 MUL → ignored; result=81.
  - Any op with rd=0 → done=1, we=0.
- Assert rst at RUN cycle 10 → next cycle busy=0, done and we never pulse. Then DIVU 50/5 completes with result=10.
